// File: rtl/dfx_rom_bist_pkg.sv
// Shared types and default constants for the ROM BIST controller and its MISR.
// Sizing defaults match a 2K x 32 ROM macro.
package dfx_rom_bist_pkg;

    localparam int          DEF_ADDR_W    = 11;
    localparam int          DEF_DATA_W    = 32;
    localparam logic [31:0] DEF_MISR_POLY = 32'h8020_0003;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_CMP   = 3'd3,
        S_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/dfx_rom_bist_misr.sv
// Multiple-input signature register: shifts in the parity of the tapped bits
// and folds one data word per enabled cycle.
module dfx_rom_bist_misr
    import dfx_rom_bist_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter logic [DATA_W-1:0] MISR_POLY = DATA_W'(DEF_MISR_POLY)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] sig
);

    logic feedback;

    assign feedback = ^(sig & MISR_POLY);

    // clr wins over en so a run always starts from an all-zero signature.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[DATA_W-2:0], feedback} ^ data;
        end
    end

endmodule

// File: rtl/dfx_rom_bist_ctrl.sv
// ROM BIST controller: sweeps every ROM address once, compresses the read data
// into a MISR and compares the final signature against a golden value.
module dfx_rom_bist_ctrl
    import dfx_rom_bist_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                ROM_LAT   = 1,
    parameter logic [DATA_W-1:0] MISR_POLY = DATA_W'(DEF_MISR_POLY),
    parameter logic [DATA_W-1:0] EXP_SIG   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mbist_en,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_ren,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_pass,
    output logic [DATA_W-1:0] bist_sig,
    output state_e            state
);

    localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;
    localparam logic [1:0]        DRAIN_LAST = 2'(ROM_LAT - 1);

    state_e              state_n;
    logic [ADDR_W-1:0]   addr_n;
    logic                ren_n;
    logic                busy_n;
    logic                done_n;
    logic                pass_n;
    logic [1:0]          drain_cnt;
    logic [1:0]          drain_n;
    logic [ROM_LAT-1:0]  vld_pipe;
    logic                pipe_clr;
    logic                misr_clr;
    logic                misr_en;

    // mbist_en is a level, not a pulse: high starts a run from IDLE and must stay
    // high through DONE; dropping it anywhere aborts or acknowledges the result.
    always_comb begin
        state_n  = state;
        addr_n   = rom_addr;
        ren_n    = 1'b0;
        busy_n   = 1'b0;
        done_n   = 1'b0;
        pass_n   = 1'b0;
        drain_n  = drain_cnt;
        pipe_clr = 1'b0;
        misr_clr = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (mbist_en) begin
                    state_n  = S_READ;
                    addr_n   = '0;
                    ren_n    = 1'b1;
                    busy_n   = 1'b1;
                    misr_clr = 1'b1;
                end
            end
            S_READ: begin
                if (!mbist_en) begin
                    state_n  = S_IDLE;
                    addr_n   = '0;
                    pipe_clr = 1'b1;
                end else if (rom_addr == ADDR_LAST) begin
                    state_n = S_DRAIN;
                    drain_n = '0;
                    busy_n  = 1'b1;
                end else begin
                    addr_n = rom_addr + 1'b1;
                    ren_n  = 1'b1;
                    busy_n = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!mbist_en) begin
                    state_n  = S_IDLE;
                    addr_n   = '0;
                    pipe_clr = 1'b1;
                end else begin
                    busy_n = 1'b1;
                    if (drain_cnt == DRAIN_LAST) begin
                        state_n = S_CMP;
                    end else begin
                        drain_n = drain_cnt + 2'd1;
                    end
                end
            end
            S_CMP: begin
                if (!mbist_en) begin
                    state_n  = S_IDLE;
                    addr_n   = '0;
                    pipe_clr = 1'b1;
                end else begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                    pass_n  = (bist_sig == EXP_SIG);
                end
            end
            S_DONE: begin
                if (!mbist_en) begin
                    state_n = S_IDLE;
                    addr_n  = '0;
                end else begin
                    done_n = 1'b1;
                    pass_n = bist_pass;
                end
            end
            default: begin
                state_n  = S_IDLE;
                addr_n   = '0;
                pipe_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rom_addr  <= '0;
            rom_ren   <= 1'b0;
            bist_busy <= 1'b0;
            bist_done <= 1'b0;
            bist_pass <= 1'b0;
            drain_cnt <= '0;
        end else begin
            state     <= state_n;
            rom_addr  <= addr_n;
            rom_ren   <= ren_n;
            bist_busy <= busy_n;
            bist_done <= done_n;
            bist_pass <= pass_n;
            drain_cnt <= drain_n;
        end
    end

    // Tracks which cycles carry ROM data; the oldest bit lines up with rom_rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else if (pipe_clr) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= (vld_pipe << 1) | ROM_LAT'(rom_ren);
        end
    end

    assign misr_en = vld_pipe[ROM_LAT-1] & mbist_en &
                     ((state == S_READ) || (state == S_DRAIN));

    dfx_rom_bist_misr #(
        .DATA_W    (DATA_W),
        .MISR_POLY (MISR_POLY)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .clr  (misr_clr),
        .en   (misr_en),
        .data (rom_rdata),
        .sig  (bist_sig)
    );

endmodule

// File: tb/tb_dfx_rom_bist_ctrl.sv
// Bench for dfx_rom_bist_ctrl: two instances (ROM latency 1 and 3) driven from a
// shared ROM image, checked against a signature model computed over that image.
module tb_dfx_rom_bist_ctrl;
    import dfx_rom_bist_pkg::*;

    localparam int          AW    = 11;
    localparam int          DW    = 32;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] POLY  = 32'h8020_0003;
    localparam logic [31:0] EXP3  = 32'h5A5A_C3C3;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic en   = 1'b0;
    logic sel3 = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    logic          en1, en3;
    logic [DW-1:0] rdata1, rdata3;
    logic [AW-1:0] addr1, addr3;
    logic          ren1, ren3, busy1, busy3, done1, done3, pass1, pass3;
    logic [DW-1:0] sig1, sig3;
    state_e        st1, st3;

    assign en1 = en & ~sel3;
    assign en3 = en & sel3;

    dfx_rom_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1), .MISR_POLY(POLY), .EXP_SIG(32'h0)) u_dut1 (
        .clk(clk), .rst(rst), .mbist_en(en1), .rom_rdata(rdata1), .rom_addr(addr1), .rom_ren(ren1),
        .bist_busy(busy1), .bist_done(done1), .bist_pass(pass1), .bist_sig(sig1), .state(st1));

    dfx_rom_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3), .MISR_POLY(POLY), .EXP_SIG(EXP3)) u_dut3 (
        .clk(clk), .rst(rst), .mbist_en(en3), .rom_rdata(rdata3), .rom_addr(addr3), .rom_ren(ren3),
        .bist_busy(busy3), .bist_done(done3), .bist_pass(pass3), .bist_sig(sig3), .state(st3));

    // Observation mux onto whichever instance is under test.
    logic          obs_ren, obs_busy, obs_done, obs_pass;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_sig;
    state_e        obs_state;
    assign obs_ren   = sel3 ? ren3  : ren1;
    assign obs_busy  = sel3 ? busy3 : busy1;
    assign obs_done  = sel3 ? done3 : done1;
    assign obs_pass  = sel3 ? pass3 : pass1;
    assign obs_addr  = sel3 ? addr3 : addr1;
    assign obs_sig   = sel3 ? sig3  : sig1;
    assign obs_state = sel3 ? st3   : st1;

    // ROM image and synchronous ROM models; non-read cycles return a poison word.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd1_q;
    logic [DW-1:0] rd3_q [3];
    always @(posedge clk) begin
        rd1_q    <= ren1 ? mem[addr1] : 32'hDEAD_BEEF;
        rd3_q[0] <= ren3 ? mem[addr3] : 32'hDEAD_BEEF;
        rd3_q[1] <= rd3_q[0];
        rd3_q[2] <= rd3_q[1];
    end
    assign rdata1 = rd1_q;
    assign rdata3 = rd3_q[2];

    function automatic logic [DW-1:0] misr_step(input logic [DW-1:0] s, input logic [DW-1:0] d);
        return {s[DW-2:0], ^(s & POLY)} ^ d;
    endfunction

    // Signature of the whole ROM image, every word folded exactly once in address order.
    function automatic logic [DW-1:0] model_sig();
        logic [DW-1:0] s;
        s = '0;
        for (int i = 0; i < DEPTH; i++) s = misr_step(s, mem[i]);
        return s;
    endfunction

    // Address pattern, with the final word steered so the image's signature is EXP3.
    task automatic fill_addr_pattern();
        logic [DW-1:0] s;
        s = '0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            mem[i] = DW'(i);
            s = misr_step(s, mem[i]);
        end
        mem[DEPTH-1] = misr_step(s, '0) ^ EXP3;
    endtask

    task automatic idle_gap();
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Raises mbist_en and watches one run; optionally drops it once abort_at is issued.
    task automatic run_collect(input int abort_at, output int issued, output bit seq_ok, output int done_cyc);
        int exp_addr;
        exp_addr = 0;
        issued   = 0;
        seq_ok   = 1'b1;
        done_cyc = -1;
        @(negedge clk);
        en = 1'b1;
        for (int j = 0; j < 3000; j++) begin
            @(posedge clk);
            #1;
            if (obs_ren) begin
                if (obs_addr !== AW'(exp_addr)) seq_ok = 1'b0;
                exp_addr++;
                issued++;
                if (abort_at >= 0 && obs_addr == AW'(abort_at)) begin
                    @(negedge clk);
                    en = 1'b0;
                    @(posedge clk);
                    #1;
                    return;
                end
            end
            if (obs_done) begin
                done_cyc = j + 1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if ({ren1, busy1, done1, pass1, ren3, busy3, done3, pass3} !== 8'h00) begin
            n_bad++; $display("FAIL reset_flags: got %b want 00000000", {ren1, busy1, done1, pass1, ren3, busy3, done3, pass3}); end
        n_cmp++; if ({sig1, sig3} !== 64'h0) begin
            n_bad++; $display("FAIL reset_sig: got %h/%h want 0", sig1, sig3); end
        n_cmp++; if ({addr1, addr3} !== '0) begin
            n_bad++; $display("FAIL reset_addr: got %h/%h want 0", addr1, addr3); end
        n_cmp++; if (st1 !== S_IDLE || st3 !== S_IDLE) begin
            n_bad++; $display("FAIL reset_state: got %0d/%0d want %0d", st1, st3, S_IDLE); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_zero_rom();
        int issued; bit seq_ok; int done_cyc;
        sel3 = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        run_collect(-1, issued, seq_ok, done_cyc);
        n_cmp++; if (issued !== DEPTH) begin n_bad++; $display("FAIL zero_issued: got %0d want %0d", issued, DEPTH); end
        n_cmp++; if (seq_ok !== 1'b1) begin n_bad++; $display("FAIL zero_addr_seq: got %0d want 1", seq_ok); end
        n_cmp++; if (done_cyc !== DEPTH + 1 + 2) begin n_bad++; $display("FAIL zero_latency: got %0d want %0d", done_cyc, DEPTH + 3); end
        n_cmp++; if (obs_pass !== 1'b1) begin n_bad++; $display("FAIL zero_pass: got %b want 1", obs_pass); end
        n_cmp++; if (obs_sig !== '0) begin n_bad++; $display("FAIL zero_sig: got %h want 0", obs_sig); end
        n_cmp++; if (obs_busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy_in_done: got %b want 0", obs_busy); end
        idle_gap();
    endtask

    task automatic test_random_rom();
        int issued; bit seq_ok; int done_cyc;
        logic [DW-1:0] exp_sig;
        sel3 = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        exp_sig = model_sig();
        run_collect(-1, issued, seq_ok, done_cyc);
        n_cmp++; if (obs_sig !== exp_sig) begin n_bad++; $display("FAIL rand_sig: got %h want %h", obs_sig, exp_sig); end
        n_cmp++; if (obs_pass !== (exp_sig == '0)) begin n_bad++; $display("FAIL rand_pass: got %b want %b", obs_pass, exp_sig == '0); end
        n_cmp++; if (done_cyc !== DEPTH + 1 + 2) begin n_bad++; $display("FAIL rand_latency: got %0d want %0d", done_cyc, DEPTH + 3); end
        idle_gap();
    endtask

    task automatic test_abort_rerun();
        int issued; bit seq_ok; int done_cyc;
        logic [DW-1:0] exp_sig;
        sel3 = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        exp_sig = model_sig();
        run_collect(500, issued, seq_ok, done_cyc);
        n_cmp++; if (issued !== 501) begin n_bad++; $display("FAIL abort_issued: got %0d want 501", issued); end
        n_cmp++; if ({obs_ren, obs_busy, obs_done, obs_pass} !== 4'b0000) begin
            n_bad++; $display("FAIL abort_outputs: got %b want 0000", {obs_ren, obs_busy, obs_done, obs_pass}); end
        n_cmp++; if (obs_state !== S_IDLE) begin n_bad++; $display("FAIL abort_state: got %0d want %0d", obs_state, S_IDLE); end
        run_collect(-1, issued, seq_ok, done_cyc);
        n_cmp++; if (issued !== DEPTH || seq_ok !== 1'b1) begin
            n_bad++; $display("FAIL rerun_addr: got %0d/%0d want %0d/1", issued, seq_ok, DEPTH); end
        n_cmp++; if (obs_sig !== exp_sig) begin n_bad++; $display("FAIL rerun_sig: got %h want %h", obs_sig, exp_sig); end
        idle_gap();
    endtask

    task automatic test_lat3_golden_and_hold();
        int issued; bit seq_ok; int done_cyc;
        bit ren_seen, done_low, pass_low;
        sel3 = 1'b1;
        fill_addr_pattern();
        run_collect(-1, issued, seq_ok, done_cyc);
        n_cmp++; if (done_cyc !== DEPTH + 3 + 2) begin n_bad++; $display("FAIL lat3_latency: got %0d want %0d", done_cyc, DEPTH + 5); end
        n_cmp++; if (issued !== DEPTH || seq_ok !== 1'b1) begin
            n_bad++; $display("FAIL lat3_addr: got %0d/%0d want %0d/1", issued, seq_ok, DEPTH); end
        n_cmp++; if (obs_sig !== model_sig()) begin n_bad++; $display("FAIL lat3_sig: got %h want %h", obs_sig, model_sig()); end
        n_cmp++; if (obs_pass !== 1'b1) begin n_bad++; $display("FAIL lat3_pass: got %b want 1", obs_pass); end
        ren_seen = 1'b0; done_low = 1'b0; pass_low = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            ren_seen |= obs_ren;
            done_low |= ~obs_done;
            pass_low |= ~obs_pass;
        end
        n_cmp++; if ({ren_seen, done_low, pass_low} !== 3'b000) begin
            n_bad++; $display("FAIL hold_high_no_rerun: got %b want 000", {ren_seen, done_low, pass_low}); end
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if ({obs_done, obs_pass} !== 2'b00) begin n_bad++; $display("FAIL ack_clear: got %b want 00", {obs_done, obs_pass}); end
        n_cmp++; if (obs_sig !== EXP3) begin n_bad++; $display("FAIL sig_held_idle: got %h want %h", obs_sig, EXP3); end
        run_collect(-1, issued, seq_ok, done_cyc);
        n_cmp++; if (obs_pass !== 1'b1 || obs_sig !== EXP3) begin
            n_bad++; $display("FAIL lat3_rerun: got %b/%h want 1/%h", obs_pass, obs_sig, EXP3); end
        idle_gap();
    endtask

    task automatic test_lat3_corrupt();
        int issued; bit seq_ok; int done_cyc;
        logic [DW-1:0] exp_sig;
        sel3 = 1'b1;
        fill_addr_pattern();
        mem[DEPTH-1] ^= DW'(1) << $urandom_range(DW - 1, 0);
        exp_sig = model_sig();
        run_collect(-1, issued, seq_ok, done_cyc);
        n_cmp++; if (obs_sig !== exp_sig) begin n_bad++; $display("FAIL last_word_sig: got %h want %h", obs_sig, exp_sig); end
        n_cmp++; if (obs_pass !== 1'b0) begin n_bad++; $display("FAIL last_word_pass: got %b want 0", obs_pass); end
        idle_gap();
        fill_addr_pattern();
        mem[1000] ^= DW'(1) << $urandom_range(DW - 1, 0);
        exp_sig = model_sig();
        run_collect(-1, issued, seq_ok, done_cyc);
        n_cmp++; if (obs_sig !== exp_sig) begin n_bad++; $display("FAIL flip1000_sig: got %h want %h", obs_sig, exp_sig); end
        n_cmp++; if (obs_pass !== 1'b0 || obs_sig === EXP3) begin
            n_bad++; $display("FAIL flip1000_pass: got %b/%h want 0/not %h", obs_pass, obs_sig, EXP3); end
        idle_gap();
    endtask

    task automatic test_reset_in_drain();
        int issued; bit seq_ok; int done_cyc;
        bit found;
        sel3 = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        found = 1'b0;
        @(negedge clk);
        en = 1'b1;
        for (int j = 0; j < 3000 && !found; j++) begin
            @(posedge clk);
            #1;
            if (obs_state == S_DRAIN) found = 1'b1;
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL drain_reached: got %b want 1", found); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if ({obs_ren, obs_busy, obs_done, obs_pass} !== 4'b0000 || obs_sig !== '0 || obs_addr !== '0) begin
            n_bad++; $display("FAIL async_reset_outputs: got %b/%h/%h want 0000/0/0", {obs_ren, obs_busy, obs_done, obs_pass}, obs_sig, obs_addr); end
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (obs_state !== S_IDLE) begin n_bad++; $display("FAIL post_reset_state: got %0d want %0d", obs_state, S_IDLE); end
        run_collect(-1, issued, seq_ok, done_cyc);
        n_cmp++; if (obs_sig !== model_sig() || issued !== DEPTH) begin
            n_bad++; $display("FAIL post_reset_run: got %h/%0d want %h/%0d", obs_sig, issued, model_sig(), DEPTH); end
        idle_gap();
    endtask

    initial begin
        test_reset();
        test_zero_rom();
        test_random_rom();
        test_abort_rerun();
        test_lat3_golden_and_hold();
        test_lat3_corrupt();
        test_reset_in_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dfx_rom_bist_ctrl.md
DFX_ROM_BIST_CTRL -- requirements
Module: dfx_rom_bist_ctrl

Interface
REQ-001 Parameter ADDR_W, default 11, ROM address width; depth = 2**ADDR_W.
REQ-002 Parameter DATA_W, default 32, ROM data and signature width.
REQ-003 Parameter ROM_LAT, default 1, range 1..3, cycles from rom_ren/rom_addr to valid rom_rdata.
REQ-004 Parameter MISR_POLY, default 32'h8020_0003, feedback tap mask.
REQ-005 Parameter EXP_SIG, default 32'h0000_0000, golden signature.
REQ-006 clk  input  1  single functional/BIST clock.
REQ-007 rst  input  1  reset, asynchronous assert, active-high.
REQ-008 mbist_en  input  1  BIST enable, already synchronized to clk; no further sync inside.
REQ-009 rom_rdata  input  DATA_W  ROM read data, valid ROM_LAT cycles after the read.
REQ-010 rom_addr  output  ADDR_W  ROM read address.
REQ-011 rom_ren  output  1  ROM read enable.
REQ-012 bist_busy  output  1  run in progress.
REQ-013 bist_done  output  1  run complete, result valid.
REQ-014 bist_pass  output  1  signature matched EXP_SIG; meaningful only while bist_done=1.
REQ-015 bist_sig  output  DATA_W  current MISR signature.

Function
REQ-016 FSM states IDLE, READ, DRAIN, CMP, DONE; all outputs registered.
REQ-017 IDLE: when mbist_en=1, go to READ next cycle with MISR cleared to 0 and address counter 0.
REQ-018 READ: rom_ren=1, rom_addr=counter; counter increments each cycle; after address 2**ADDR_W-1 is issued, go to DRAIN (no wrap to 0 issued).
REQ-019 DRAIN: rom_ren=0; last for exactly ROM_LAT cycles, then go to CMP.
REQ-020 MISR update on every cycle where data from a read is valid (read-valid pipeline of depth ROM_LAT): sig_next = ({sig[DATA_W-2:0], ^(sig & MISR_POLY)}) ^ rom_rdata.
REQ-021 Exactly 2**ADDR_W data words are compressed per run, none skipped, none repeated.
REQ-022 CMP: one cycle; register pass = (sig == EXP_SIG); go to DONE.
REQ-023 DONE: bist_done=1, bist_busy=0, bist_pass held; stay until mbist_en=0, then go to IDLE, clearing bist_done and bist_pass.
REQ-024 bist_busy=1 in READ, DRAIN and CMP only.
REQ-025 Latency: with mbist_en first sampled high at cycle 0, bist_done rises at cycle 2**ADDR_W + ROM_LAT + 2 (2051 for the defaults).
REQ-026 Abort: mbist_en=0 in READ/DRAIN/CMP causes IDLE next cycle, rom_ren=0, busy=0, done=0, pass=0, and in-flight read data is discarded.
REQ-027 A new run requires mbist_en low for at least one cycle, then high; mbist_en held high after DONE starts no rerun.
REQ-028 bist_sig holds its last value in DONE and IDLE and is cleared only at run start or reset.

Reset
REQ-029 rst=1 asynchronously forces IDLE, counter=0, read-valid pipe=0, sig=0, and all outputs 0.
REQ-030 Reset deassertion is synchronous to clk by construction upstream; a reset mid-run aborts with no residual state.

Structure
REQ-031 Package dfx_rom_bist_pkg holds the FSM state enum and the default ADDR_W/DATA_W/MISR_POLY constants.
REQ-032 The MISR is a sub-module dfx_rom_bist_misr (clear, enable, data in, sig out), parameterized by DATA_W and MISR_POLY.

Verification
REQ-033 ROM all zeros, EXP_SIG=0, ROM_LAT=1, mbist_en rises -> addresses 0..2047 issued once each, done at cycle 2051, pass=1, sig=0.
REQ-034 ROM model with rdata=address, EXP_SIG from a reference model -> pass=1; flip one bit of word 1000 -> pass=0 and sig differs.
REQ-035 Drop mbist_en at READ address 500 -> IDLE next cycle, rom_ren=0, done=0; re-raise -> full run from address 0 with a correct signature.
REQ-036 Assert rst during DRAIN -> all outputs 0 in the same cycle (async), state IDLE after release.
REQ-037 ROM_LAT=3 -> done at cycle 2053, last word included in sig; mbist_en held high after DONE -> no second run until low-then-high.
